// File: rtl/complex_matrix_hmul_seq_if.sv
// Request/result bundle for complex_matrix_hmul_seq: the flat H and Y operands
// and start go in; Z_out_flat, busy and done come back.
interface complex_matrix_hmul_seq_if #(
    parameter int N = 16
) ();
    // start is a request sampled only while busy is low. It is taken on that
    // same edge, with no queuing. done pulses for one cycle when Z_out_flat
    // changes, and Z_out_flat then holds until the next done.
    logic              start;
    logic [32*N-1:0]   H_in_flat;
    logic [16*N-1:0]   Y_in_flat;
    logic [16*N-1:0]   Z_out_flat;
    logic              busy;
    logic              done;

    modport master (
        output start, H_in_flat, Y_in_flat,
        input  Z_out_flat, busy, done
    );

    modport slave (
        input  start, H_in_flat, Y_in_flat,
        output Z_out_flat, busy, done
    );
endinterface

// File: rtl/complex_matrix_hmul_seq.sv
// Z = H^H * Y (H 4x4, Y 4x2, complex Q-format), one complex MAC per cycle over 32 cycles.
// Define CMHMUL_ROUND_EN to round each term half-up before the >>>Q shift instead of truncating.
module complex_matrix_hmul_seq #(
    parameter int Q    = 8,
    parameter int N    = 16,
    parameter int ACCW = N + 4
) (
    input  logic                     clk,
    input  logic                     rst,
    complex_matrix_hmul_seq_if.slave bus,
    output logic [1:0]               dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    localparam int SW = 2 * N + 1;
    // A full-scale term is ~2^(2N-1-Q), and four of them must fit so that
    // saturation sees the true sum; ACCW is widened when it is too narrow.
    localparam int AW = (ACCW > SW - Q + 2) ? ACCW : SW - Q + 2;

    localparam logic signed [AW-1:0] SAT_MAX = AW'((64'sd1 <<< (N - 1)) - 64'sd1);
    localparam logic signed [AW-1:0] SAT_MIN = AW'(-(64'sd1 <<< (N - 1)));
`ifdef CMHMUL_ROUND_EN
    localparam logic signed [SW-1:0] RND = SW'(64'sd1 <<< (Q - 1));
`endif

    state_t state_q, state_d;

    logic [32*N-1:0]        h_q;
    logic [16*N-1:0]        y_q;
    logic [16*N-1:0]        zres_q;
    logic [16*N-1:0]        z_out_q;
    logic signed [AW-1:0]   acc_re_q, acc_im_q;
    logic [4:0]             cnt_q;
    logic                   done_q;

    logic capture, mac_en, out_en;

    logic [1:0]             k_idx, i_idx;
    logic                   j_idx;
    int                     h_base, y_base, z_base;
    logic signed [N-1:0]    hr, hi, yr, yi;
    logic signed [2*N-1:0]  p_rr, p_ii, p_ri, p_ir;
    logic signed [SW-1:0]   re_full, im_full;
    logic signed [SW-1:0]   re_shift, im_shift;
    logic signed [AW-1:0]   term_re, term_im;
    logic signed [AW-1:0]   acc_sum_re, acc_sum_im;

    function automatic logic [N-1:0] sat_n(input logic signed [AW-1:0] v);
        logic signed [AW-1:0] c;
        if (v > SAT_MAX) begin
            c = SAT_MAX;
        end else if (v < SAT_MIN) begin
            c = SAT_MIN;
        end else begin
            c = v;
        end
        return c[N-1:0];
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_MAC;
            S_MAC:   if (cnt_q == 5'd31) state_d = S_OUT;
            S_OUT:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        capture     = (state_q == S_IDLE) && bus.start;
        mac_en      = (state_q == S_MAC);
        out_en      = (state_q == S_OUT);
        bus.busy    = (state_q != S_IDLE);
        bus.done    = done_q;
        bus.Z_out_flat = z_out_q;
        dbg_state_o = state_q;
    end

    // One complex term conj(H[k][i]) * Y[k][j] selected by the counter
    always_comb begin
        k_idx  = cnt_q[1:0];
        j_idx  = cnt_q[2];
        i_idx  = cnt_q[4:3];
        h_base = ((int'(k_idx) * 4 + int'(i_idx)) * 2) * N;
        y_base = ((int'(k_idx) * 2 + int'(j_idx)) * 2) * N;
        z_base = ((int'(i_idx) * 2 + int'(j_idx)) * 2) * N;

        hr = h_q[h_base +: N];
        hi = h_q[h_base + N +: N];
        yr = y_q[y_base +: N];
        yi = y_q[y_base + N +: N];

        p_rr = hr * yr;
        p_ii = hi * yi;
        p_ri = hr * yi;
        p_ir = hi * yr;

        re_full = SW'(p_rr) + SW'(p_ii);
        im_full = SW'(p_ri) - SW'(p_ir);
`ifdef CMHMUL_ROUND_EN
        re_full = re_full + RND;
        im_full = im_full + RND;
`endif
        re_shift = re_full >>> Q;
        im_shift = im_full >>> Q;
        term_re  = AW'(re_shift);
        term_im  = AW'(im_shift);

        if (k_idx == 2'd0) begin
            acc_sum_re = term_re;
            acc_sum_im = term_im;
        end else begin
            acc_sum_re = acc_re_q + term_re;
            acc_sum_im = acc_im_q + term_im;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            h_q      <= '0;
            y_q      <= '0;
            zres_q   <= '0;
            z_out_q  <= '0;
            acc_re_q <= '0;
            acc_im_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= out_en;
            if (capture) begin
                h_q      <= bus.H_in_flat;
                y_q      <= bus.Y_in_flat;
                acc_re_q <= '0;
                acc_im_q <= '0;
                cnt_q    <= '0;
            end
            if (mac_en) begin
                acc_re_q <= acc_sum_re;
                acc_im_q <= acc_sum_im;
                cnt_q    <= cnt_q + 5'd1;
                if (k_idx == 2'd3) begin
                    zres_q[z_base +: N]     <= sat_n(acc_sum_re);
                    zres_q[z_base + N +: N] <= sat_n(acc_sum_im);
                end
            end
            // Only whole results reach the output, on the single OUT edge
            if (out_en) begin
                z_out_q <= zres_q;
            end
        end
    end

endmodule

// File: tb/tb_complex_matrix_hmul_seq.sv
// Bench for complex_matrix_hmul_seq: directed cases plus random operands checked
// against a plain-arithmetic model of Z = H^H * Y.
module tb_complex_matrix_hmul_seq;
  localparam int N = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  complex_matrix_hmul_seq_if #(.N(N)) bus ();
  logic [1:0] dbg_state;

  complex_matrix_hmul_seq #(.Q(8), .N(N), .ACCW(N + 4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [255:0] exp_q[$];
  logic [511:0] h_v;
  logic [255:0] y_v;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] sat16(input longint v);
    logic [63:0] t;
    if (v > 32767) return 16'h7fff;
    if (v < -32768) return 16'h8000;
    t = v;
    return t[15:0];
  endfunction

  function automatic logic [255:0] model_z(input logic [511:0] h, input logic [255:0] y);
    logic [255:0] z;
    longint hr, hi, yr, yi, tr, ti, sr, si;
    z = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 2; j++) begin
        sr = 0;
        si = 0;
        for (int k = 0; k < 4; k++) begin
          hr = longint'($signed(h[((k*4+i)*2)*N +: N]));
          hi = longint'($signed(h[((k*4+i)*2+1)*N +: N]));
          yr = longint'($signed(y[((k*2+j)*2)*N +: N]));
          yi = longint'($signed(y[((k*2+j)*2+1)*N +: N]));
          tr = hr * yr + hi * yi;
          ti = hr * yi - hi * yr;
`ifdef CMHMUL_ROUND_EN
          tr = tr + 128;
          ti = ti + 128;
`endif
          sr = sr + (tr >>> 8);
          si = si + (ti >>> 8);
        end
        z[((i*2+j)*2)*N +: N]   = sat16(sr);
        z[((i*2+j)*2+1)*N +: N] = sat16(si);
      end
    end
    return z;
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int w = 0; w < 16; w++) v[w*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int w = 0; w < 8; w++) v[w*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic put_h(input int i, input int j, input logic [15:0] re, input logic [15:0] im);
    h_v[((i*4+j)*2)*N +: N]   = re;
    h_v[((i*4+j)*2+1)*N +: N] = im;
  endtask

  task automatic put_y(input int i, input int j, input logic [15:0] re, input logic [15:0] im);
    y_v[((i*2+j)*2)*N +: N]   = re;
    y_v[((i*2+j)*2+1)*N +: N] = im;
  endtask

  task automatic fill_all(input logic [15:0] hre, input logic [15:0] him,
                          input logic [15:0] yre, input logic [15:0] yim);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) put_h(i, j, hre, him);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 2; j++) put_y(i, j, yre, yim);
  endtask

  function automatic logic [255:0] z_fill(input logic [15:0] re, input logic [15:0] im);
    logic [255:0] z;
    for (int e = 0; e < 8; e++) begin
      z[(e*2)*N +: N]   = re;
      z[(e*2+1)*N +: N] = im;
    end
    return z;
  endfunction

  // ---------------- driver tasks ----------------
  // Presents h_v/y_v with start for one edge, then scrambles the inputs.
  task automatic capture();
    @(negedge clk);
    bus.H_in_flat = h_v;
    bus.Y_in_flat = y_v;
    bus.start     = 1'b1;
    @(posedge clk);
    exp_q.push_back(model_z(h_v, y_v));
    #1;
    bus.start     = 1'b0;
    bus.H_in_flat = rand512();
    bus.Y_in_flat = rand256();
  endtask

  task automatic wait_done(input string tag);
    int lat;
    logic busy_ok;
    logic [255:0] exp;
    lat = 0;
    busy_ok = 1'b1;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done) break;
      if (!bus.busy) busy_ok = 1'b0;
    end
    check_eq({tag, "_lat"}, 256'(lat), 256'(33));
    check_eq({tag, "_busy_run"}, 256'(busy_ok), 256'(1));
    check_eq({tag, "_busy_end"}, 256'(bus.busy), 256'(0));
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    check_eq({tag, "_z"}, bus.Z_out_flat, exp);
    @(posedge clk);
    #1;
    check_eq({tag, "_done_pulse"}, 256'(bus.done), 256'(0));
  endtask

  task automatic run_op(input string tag);
    capture();
    wait_done(tag);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [255:0] m;
    logic [255:0] z_prev;
    logic stable_ok;
    int d_at[$];
    int extra;
    int seen;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.H_in_flat = '0;
    bus.Y_in_flat = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_z", bus.Z_out_flat, '0);
    check_eq("reset_busy", 256'(bus.busy), 256'(0));
    check_eq("reset_done", 256'(bus.done), 256'(0));
    @(negedge clk);
    rst = 1'b0;

    // Identity H: Z equals Y
    h_v = '0;
    y_v = '0;
    for (int i = 0; i < 4; i++) put_h(i, i, 16'd256, 16'd0);
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 2; j++) put_y(k, j, 16'((2*k + j + 1) * 256 - j * 256 * k), 16'd0);
    run_op("ident");
    check_eq("ident_eq_y", bus.Z_out_flat, y_v);

    // Conjugation: H = 0+256j, Y = 256 -> Z = 0 - 1024j
    fill_all(16'd0, 16'd256, 16'd256, 16'd0);
    run_op("conj");
    check_eq("conj_val", bus.Z_out_flat, z_fill(16'd0, 16'hfc00));

    // Saturation both directions
    fill_all(16'd16384, 16'd0, 16'd16384, 16'd0);
    run_op("sat_pos");
    check_eq("sat_pos_val", bus.Z_out_flat, z_fill(16'h7fff, 16'd0));
    fill_all(16'd16384, 16'd0, 16'hc000, 16'd0);
    run_op("sat_neg");
    check_eq("sat_neg_val", bus.Z_out_flat, z_fill(16'h8000, 16'd0));

    // Rounding versus truncation on a half-LSB term
    h_v = '0;
    y_v = '0;
    put_h(0, 0, 16'd1, 16'd0);
    put_y(0, 0, 16'd128, 16'd0);
    run_op("rnd_pos");
`ifdef CMHMUL_ROUND_EN
    check_eq("rnd_pos_z00", 256'(bus.Z_out_flat[15:0]), 256'(16'd1));
`else
    check_eq("rnd_pos_z00", 256'(bus.Z_out_flat[15:0]), 256'(16'd0));
`endif
    put_h(0, 0, 16'hffff, 16'd0);
    run_op("rnd_neg");
`ifdef CMHMUL_ROUND_EN
    check_eq("rnd_neg_z00", 256'(bus.Z_out_flat[15:0]), 256'(16'd0));
`else
    check_eq("rnd_neg_z00", 256'(bus.Z_out_flat[15:0]), 256'(16'hffff));
`endif

    // Random operands
    for (int r = 0; r < 6; r++) begin
      h_v = rand512();
      y_v = rand256();
      run_op($sformatf("rand%0d", r));
    end

    // Start held high for 100 cycles: done at +33 and +67, Z stable in between
    h_v = rand512();
    y_v = rand256();
    m = model_z(h_v, y_v);
    @(negedge clk);
    bus.H_in_flat = h_v;
    bus.Y_in_flat = y_v;
    bus.start = 1'b1;
    z_prev = bus.Z_out_flat;
    stable_ok = 1'b1;
    for (int e = 0; e < 100; e++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        d_at.push_back(e);
        check_eq("held_z", bus.Z_out_flat, m);
        z_prev = bus.Z_out_flat;
      end else if (bus.Z_out_flat !== z_prev) begin
        stable_ok = 1'b0;
      end
    end
    check_eq("held_ndone", 256'(d_at.size()), 256'(2));
    check_eq("held_d0", 256'((d_at.size() > 0) ? d_at[0] : -1), 256'(33));
    check_eq("held_d1", 256'((d_at.size() > 1) ? d_at[1] : -1), 256'(67));
    check_eq("held_stable", 256'(stable_ok), 256'(1));
    @(negedge clk);
    bus.start = 1'b0;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        seen = 1;
        break;
      end
    end
    check_eq("held_drain_done", 256'(seen), 256'(1));
    check_eq("held_drain_z", bus.Z_out_flat, m);
    repeat (2) @(posedge clk);

    // Start pulsed during MAC is ignored
    h_v = rand512();
    y_v = rand256();
    fork
      begin
        repeat (10) @(negedge clk);
        bus.H_in_flat = rand512();
        bus.Y_in_flat = rand256();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
      end
    join_none
    run_op("pulse");
    extra = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (bus.done) extra++;
    end
    check_eq("pulse_no_extra", 256'(extra), 256'(0));
    check_eq("pulse_z_kept", bus.Z_out_flat, model_z(h_v, y_v));

    // Reset while the MAC counter is at 10
    h_v = rand512();
    y_v = rand256();
    capture();
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    check_eq("mid_rst_done", 256'(bus.done), 256'(0));
    check_eq("mid_rst_busy", 256'(bus.busy), 256'(0));
    check_eq("mid_rst_z", bus.Z_out_flat, '0);
    @(negedge clk);
    rst = 1'b0;
    h_v = rand512();
    y_v = rand256();
    run_op("after_rst");

    // start together with rst: reset wins
    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_vs_start_busy", 256'(bus.busy), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rst_vs_start_idle", 256'(bus.busy), 256'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
